// File: rtl/flash_pkg.sv
// Shared opcodes, mode encodings and FSM state encoding for the flash erase engine.
package flash_pkg;

  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_SE   = 8'hD8;
  localparam logic [7:0] OP_SSE  = 8'h20;
  localparam logic [7:0] OP_BE   = 8'hC7;
  localparam logic [7:0] OP_RDSR = 8'h05;

  localparam logic [1:0] MODE_SECTOR    = 2'b00;
  localparam logic [1:0] MODE_SUBSECTOR = 2'b01;
  localparam logic [1:0] MODE_BULK      = 2'b10;
  localparam logic [1:0] MODE_RSVD      = 2'b11;

  // One-hot so that each pin-level output decodes from a single state flop.
  typedef enum logic [7:0] {
    ST_IDLE  = 8'b0000_0001,
    ST_WREN  = 8'b0000_0010,
    ST_GAP_A = 8'b0000_0100,
    ST_ERASE = 8'b0000_1000,
    ST_GAP_B = 8'b0001_0000,
    ST_POLL  = 8'b0010_0000,
    ST_GAP_P = 8'b0100_0000,
    ST_FIN   = 8'b1000_0000
  } state_e;

  // Longest frame: erase opcode plus address, or the 16-bit status read.
  function automatic int frame_max_bits(input int addr_bytes);
    return (8 + 8 * addr_bytes > 16) ? (8 + 8 * addr_bytes) : 16;
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 shifter: sends nbits of a left-aligned tx vector MSB first and
// shifts miso into rx on every rising sck edge.
module spi_shift_engine #(
  parameter int CLK_DIV  = 2,
  parameter int MAX_BITS = 32,
  parameter int RX_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic [$clog2(MAX_BITS+1)-1:0] nbits,
  input  logic [MAX_BITS-1:0]           tx,
  input  logic                          miso,
  output logic                          sck,
  output logic                          mosi,
  output logic [RX_W-1:0]               rx,
  output logic                          frame_done
);

  localparam int NB_W  = $clog2(MAX_BITS + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic                active_q, active_d;
  logic                sck_q, sck_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [NB_W-1:0]     bit_q, bit_d;
  logic [NB_W-1:0]     nbits_q, nbits_d;
  logic [MAX_BITS-1:0] tx_q, tx_d;
  logic [RX_W-1:0]     rx_q, rx_d;

  // Divider walks each half-bit; sck rises mid-bit, falls (and shifts) at bit end.
  always_comb begin
    active_d   = active_q;
    sck_d      = sck_q;
    div_d      = div_q;
    bit_d      = bit_q;
    nbits_d    = nbits_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    frame_done = 1'b0;
    if (load) begin
      active_d = 1'b1;
      sck_d    = 1'b0;
      div_d    = '0;
      bit_d    = '0;
      nbits_d  = nbits;
      tx_d     = tx;
    end else if (active_q) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        if (!sck_q) begin
          sck_d = 1'b1;
          rx_d  = (rx_q << 1) | RX_W'(miso);
        end else begin
          sck_d = 1'b0;
          tx_d  = tx_q << 1;
          bit_d = bit_q + NB_W'(1);
          if (bit_q == nbits_q - NB_W'(1)) begin
            active_d   = 1'b0;
            frame_done = 1'b1;
          end
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  // Control state: cleared by reset so a frame aborts at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      sck_q    <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      nbits_q  <= '0;
    end else begin
      active_q <= active_d;
      sck_q    <= sck_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      nbits_q  <= nbits_d;
    end
  end

  // Shift data: always reloaded before use, so no reset.
  always_ff @(posedge clk) begin
    tx_q <= tx_d;
    rx_q <= rx_d;
  end

  assign sck  = sck_q;
  assign mosi = active_q & tx_q[MAX_BITS-1];
  assign rx   = rx_q;

endmodule

// File: rtl/flash_erase_ctrl.sv
// SPI-flash erase sequencer: WREN, erase command, then RDSR polling until WIP
// clears or the poll limit is reached.
module flash_erase_ctrl
  import flash_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int ADDR_BYTES = 3,
  parameter int CS_GAP     = 6,
  parameter int MAX_POLLS  = 65535
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [8*ADDR_BYTES-1:0] addr,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    sck,
  output logic                    cs_n,
  output logic                    mosi,
  input  logic                    miso
);

  localparam int ADDR_W = 8 * ADDR_BYTES;
  localparam int MAXB   = frame_max_bits(ADDR_BYTES);
  localparam int NB_W   = $clog2(MAXB + 1);
  localparam int GAP_W  = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam int PC_W   = $clog2(MAX_POLLS + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [PC_W-1:0]   poll_q, poll_d;
  logic [PC_W-1:0]   poll_inc;
  logic              gap_last;

  logic              eng_load;
  logic [NB_W-1:0]   eng_nbits;
  logic [MAXB-1:0]   eng_tx;
  logic [0:0]        eng_rx;
  logic              frame_done;

  // Only the final status bit (WIP) is needed, so the rx register is one bit.
  spi_shift_engine #(
    .CLK_DIV  (CLK_DIV),
    .MAX_BITS (MAXB),
    .RX_W     (1)
  ) u_engine (
    .clk        (sys_clk),
    .rst_n      (sys_rst_n),
    .load       (eng_load),
    .nbits      (eng_nbits),
    .tx         (eng_tx),
    .miso       (miso),
    .sck        (sck),
    .mosi       (mosi),
    .rx         (eng_rx),
    .frame_done (frame_done)
  );

  assign gap_last = (gap_q == GAP_LAST);

  // Next-state logic; each frame is loaded one cycle ahead so its first bit
  // starts on the same cycle cs_n falls.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    addr_d    = addr_q;
    err_d     = err_q;
    gap_d     = gap_q;
    poll_d    = poll_q;
    poll_inc  = poll_q + PC_W'(1);
    eng_load  = 1'b0;
    eng_nbits = NB_W'(8);
    eng_tx    = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d = mode;
          addr_d = addr;
          poll_d = '0;
          if (mode == MODE_RSVD) begin
            err_d   = 1'b1;
            state_d = ST_FIN;
          end else begin
            err_d              = 1'b0;
            state_d            = ST_WREN;
            eng_load           = 1'b1;
            eng_tx[MAXB-1 -: 8] = OP_WREN;
          end
        end
      end
      ST_WREN: begin
        if (frame_done) begin
          gap_d   = '0;
          state_d = ST_GAP_A;
        end
      end
      ST_GAP_A: begin
        if (gap_last) begin
          state_d  = ST_ERASE;
          eng_load = 1'b1;
          case (mode_q)
            MODE_BULK: eng_tx[MAXB-1 -: 8] = OP_BE;
            MODE_SUBSECTOR: begin
              eng_tx[MAXB-1 -: 8+ADDR_W] = {OP_SSE, addr_q};
              eng_nbits                 = NB_W'(8 + ADDR_W);
            end
            default: begin
              eng_tx[MAXB-1 -: 8+ADDR_W] = {OP_SE, addr_q};
              eng_nbits                 = NB_W'(8 + ADDR_W);
            end
          endcase
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      ST_ERASE: begin
        if (frame_done) begin
          gap_d   = '0;
          state_d = ST_GAP_B;
        end
      end
      ST_GAP_B, ST_GAP_P: begin
        if (gap_last) begin
          state_d             = ST_POLL;
          eng_load            = 1'b1;
          eng_nbits           = NB_W'(16);
          eng_tx[MAXB-1 -: 8] = OP_RDSR;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      ST_POLL: begin
        if (frame_done) begin
          if (!eng_rx[0]) begin
            err_d   = 1'b0;
            state_d = ST_FIN;
          end else if (poll_inc == PC_W'(MAX_POLLS)) begin
            poll_d  = poll_inc;
            err_d   = 1'b1;
            state_d = ST_FIN;
          end else begin
            poll_d  = poll_inc;
            gap_d   = '0;
            state_d = ST_GAP_P;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers with asynchronous reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      gap_q   <= '0;
      poll_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      gap_q   <= gap_d;
      poll_q  <= poll_d;
    end
  end

  // Latched request data, only meaningful after an accept.
  always_ff @(posedge sys_clk) begin
    mode_q <= mode_d;
    addr_q <= addr_d;
  end

  assign cs_n = !((state_q == ST_WREN) || (state_q == ST_ERASE) || (state_q == ST_POLL));
  assign busy = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign done = (state_q == ST_FIN);
  assign err  = err_q;

endmodule

// File: tb/tb_flash_erase_ctrl.sv
// Directed bench for flash_erase_ctrl with a frame-recording flash model.
module tb_flash_erase_ctrl;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        start     = 1'b0;
  logic [1:0]  mode      = 2'b00;
  logic [23:0] addr      = 24'h0;
  logic        busy, done, err, sck, cs_n, mosi, miso;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 sys_clk = ~sys_clk;

  flash_erase_ctrl #(
    .CLK_DIV    (2),
    .ADDR_BYTES (3),
    .CS_GAP     (6),
    .MAX_POLLS  (4)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .mode      (mode),
    .addr      (addr),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .sck       (sck),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso)
  );

  bit          mon_clr   = 1'b0;
  int          wip_polls = 0;
  bit          wip_stuck = 1'b0;
  int          n_frm     = 0;
  int          cur_len   = 0;
  int          gap_run   = 0;
  int          idle_viol = 0;
  logic [63:0] cur_data  = '0;
  logic        cs_prev   = 1'b1;
  logic        sck_prev  = 1'b0;
  int          frm_len  [16];
  int          frm_gap  [16];
  logic [63:0] frm_data [16];

  // Status byte is all WIP; frames 0/1 are WREN/ERASE, so poll k is frame k+1.
  assign miso = !cs_n && (wip_stuck || (n_frm < wip_polls + 2));

  // Frame recorder: length in cycles, mosi bits at sck rise, preceding gap.
  always @(negedge sys_clk) begin
    if (mon_clr) begin
      n_frm     <= 0;
      cur_len   <= 0;
      cur_data  <= '0;
      gap_run   <= 0;
      idle_viol <= 0;
    end else if (!cs_n) begin
      if (cs_prev) begin
        if (n_frm < 16) frm_gap[n_frm] <= gap_run;
        gap_run  <= 0;
        cur_len  <= 1;
        cur_data <= '0;
      end else begin
        cur_len <= cur_len + 1;
        if (sck && !sck_prev) cur_data <= {cur_data[62:0], mosi};
      end
    end else begin
      if (!cs_prev) begin
        if (n_frm < 16) begin
          frm_len[n_frm]  <= cur_len;
          frm_data[n_frm] <= cur_data;
        end
        n_frm <= n_frm + 1;
      end
      if (busy) gap_run <= gap_run + 1;
      if (sck || mosi) idle_viol <= idle_viol + 1;
    end
    cs_prev  <= cs_n;
    sck_prev <= sck;
  end

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge sys_clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic pulse_start(input logic [1:0] m, input logic [23:0] a);
    @(posedge sys_clk);
    #1 start = 1'b1; mode = m; addr = a;
    @(posedge sys_clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output int cyc, output bit seen);
    seen = 1'b0;
    cyc  = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge sys_clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        cyc  = i + 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2 sys_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({sck, cs_n, mosi} !== 3'b010) $display("FAIL reset_pins: sck/cs_n/mosi=%b want 010", {sck, cs_n, mosi});
    else n_pass++;
    n_checks++;
    if ({busy, done, err} !== 3'b000) $display("FAIL reset_hs: busy/done/err=%b want 000", {busy, done, err});
    else n_pass++;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk) sys_rst_n = 1'b1;
    repeat (5) @(posedge sys_clk);
    #1;
    n_checks++;
    if ({cs_n, busy, done} !== 3'b100) $display("FAIL reset_idle: cs_n/busy/done=%b want 100", {cs_n, busy, done});
    else n_pass++;
  endtask

  task automatic test_sector();
    int          exp_len [3] = '{32, 128, 64};
    int          exp_gap [3] = '{0, 6, 6};
    logic [63:0] exp_data[3] = '{64'h06, 64'hD8000425, 64'h0500};
    int cyc; bit seen;
    clear_mon(); wip_polls = 0; wip_stuck = 1'b0;
    pulse_start(2'b00, 24'h000425);
    n_checks++;
    if ({busy, cs_n} !== 2'b10) $display("FAIL sector_accept: busy/cs_n=%b want 10", {busy, cs_n});
    else n_pass++;
    wait_done(400, cyc, seen);
    n_checks++;
    if (!seen || cyc !== 237) $display("FAIL sector_latency: seen=%0d cycles=%0d want 237", seen, cyc);
    else n_pass++;
    n_checks++;
    if ({err, busy} !== 2'b00) $display("FAIL sector_done: err/busy=%b want 00", {err, busy});
    else n_pass++;
    @(posedge sys_clk); #1;
    n_checks++;
    if (done !== 1'b0) $display("FAIL sector_pulse: done=%b want 0", done);
    else n_pass++;
    repeat (2) @(posedge sys_clk); #1;
    n_checks++;
    if (n_frm !== 3) $display("FAIL sector_nfrm: frames=%0d want 3", n_frm);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (frm_len[i] !== exp_len[i] || frm_data[i] !== exp_data[i] || frm_gap[i] !== exp_gap[i])
        $display("FAIL sector_frame%0d: len=%0d data=%h gap=%0d want len=%0d data=%h gap=%0d",
                 i, frm_len[i], frm_data[i], frm_gap[i], exp_len[i], exp_data[i], exp_gap[i]);
      else n_pass++;
    end
    n_checks++;
    if (idle_viol !== 0) $display("FAIL sector_idle_pins: violations=%0d want 0", idle_viol);
    else n_pass++;
  endtask

  task automatic test_bulk();
    int          exp_len [3] = '{32, 32, 64};
    logic [63:0] exp_data[3] = '{64'h06, 64'hC7, 64'h0500};
    int cyc; bit seen;
    clear_mon(); wip_polls = 0; wip_stuck = 1'b0;
    pulse_start(2'b10, 24'hABCDEF);
    wait_done(400, cyc, seen);
    n_checks++;
    if (!seen || cyc !== 141 || err !== 1'b0) $display("FAIL bulk_done: seen=%0d cycles=%0d err=%b want 141 err 0", seen, cyc, err);
    else n_pass++;
    repeat (3) @(posedge sys_clk); #1;
    n_checks++;
    if (n_frm !== 3) $display("FAIL bulk_nfrm: frames=%0d want 3", n_frm);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (frm_len[i] !== exp_len[i] || frm_data[i] !== exp_data[i])
        $display("FAIL bulk_frame%0d: len=%0d data=%h want len=%0d data=%h", i, frm_len[i], frm_data[i], exp_len[i], exp_data[i]);
      else n_pass++;
    end
  endtask

  task automatic test_poll_limit();
    int cyc; bit seen;
    clear_mon(); wip_polls = 0; wip_stuck = 1'b1;
    pulse_start(2'b00, 24'h010000);
    wait_done(800, cyc, seen);
    n_checks++;
    if (!seen || cyc !== 447) $display("FAIL limit_latency: seen=%0d cycles=%0d want 447", seen, cyc);
    else n_pass++;
    n_checks++;
    if ({err, busy} !== 2'b10) $display("FAIL limit_done: err/busy=%b want 10", {err, busy});
    else n_pass++;
    repeat (3) @(posedge sys_clk); #1;
    n_checks++;
    if (err !== 1'b1) $display("FAIL limit_err_hold: err=%b want 1", err);
    else n_pass++;
    n_checks++;
    if (n_frm !== 6) $display("FAIL limit_nfrm: frames=%0d want 6", n_frm);
    else n_pass++;
    for (int i = 2; i < 6; i++) begin
      n_checks++;
      if (frm_len[i] !== 64 || frm_data[i] !== 64'h0500 || frm_gap[i] !== 6)
        $display("FAIL limit_poll%0d: len=%0d data=%h gap=%0d want 64 0500 6", i - 1, frm_len[i], frm_data[i], frm_gap[i]);
      else n_pass++;
    end
    wip_stuck = 1'b0;
  endtask

  task automatic test_wip_polls();
    int cyc; bit seen;
    clear_mon(); wip_polls = 3; wip_stuck = 1'b0;
    pulse_start(2'b01, 24'h123456);
    n_checks++;
    if ({err, busy} !== 2'b01) $display("FAIL wip_accept: err/busy=%b want 01", {err, busy});
    else n_pass++;
    wait_done(800, cyc, seen);
    n_checks++;
    if (!seen || cyc !== 447 || err !== 1'b0) $display("FAIL wip_done: seen=%0d cycles=%0d err=%b want 447 err 0", seen, cyc, err);
    else n_pass++;
    repeat (3) @(posedge sys_clk); #1;
    n_checks++;
    if (n_frm !== 6 || frm_data[1] !== 64'h20123456 || frm_len[1] !== 128)
      $display("FAIL wip_frames: frames=%0d erase=%h len=%0d want 6 20123456 128", n_frm, frm_data[1], frm_len[1]);
    else n_pass++;
    wip_polls = 0;
  endtask

  task automatic test_reserved();
    clear_mon();
    pulse_start(2'b11, 24'h000425);
    n_checks++;
    if ({done, err, busy, cs_n} !== 4'b1101) $display("FAIL rsvd_fin: done/err/busy/cs_n=%b want 1101", {done, err, busy, cs_n});
    else n_pass++;
    @(posedge sys_clk); #1;
    n_checks++;
    if ({done, err, busy} !== 3'b010) $display("FAIL rsvd_after: done/err/busy=%b want 010", {done, err, busy});
    else n_pass++;
    repeat (10) @(posedge sys_clk); #1;
    n_checks++;
    if (n_frm !== 0 || idle_viol !== 0) $display("FAIL rsvd_quiet: frames=%0d violations=%0d want 0 0", n_frm, idle_viol);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    pulse_start(2'b00, 24'h000425);
    repeat (80) @(posedge sys_clk); #1;
    n_checks++;
    if ({sck, cs_n} !== 2'b10) $display("FAIL midrst_pre: sck/cs_n=%b want 10", {sck, cs_n});
    else n_pass++;
    sys_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cs_n, sck, mosi, busy, done} !== 5'b10000) $display("FAIL midrst_abort: cs_n/sck/mosi/busy/done=%b want 10000", {cs_n, sck, mosi, busy, done});
    else n_pass++;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk) sys_rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    int cyc; bit seen;
    clear_mon(); wip_polls = 0; wip_stuck = 1'b0;
    pulse_start(2'b00, 24'h000425);
    repeat (50) @(posedge sys_clk);
    pulse_start(2'b10, 24'hFFFFFF);
    wait_done(400, cyc, seen);
    n_checks++;
    if (!seen || cyc !== 185 || err !== 1'b0) $display("FAIL b2b_done: seen=%0d cycles=%0d err=%b want 185 err 0", seen, cyc, err);
    else n_pass++;
    repeat (40) @(posedge sys_clk); #1;
    n_checks++;
    if (n_frm !== 3 || frm_data[0] !== 64'h06 || frm_data[1] !== 64'hD8000425)
      $display("FAIL b2b_frames: frames=%0d f0=%h f1=%h want 3 06 d8000425", n_frm, frm_data[0], frm_data[1]);
    else n_pass++;
    n_checks++;
    if ({busy, cs_n} !== 2'b01) $display("FAIL b2b_idle: busy/cs_n=%b want 01", {busy, cs_n});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sector();
    test_bulk();
    test_poll_limit();
    test_wip_polls();
    test_reserved();
    test_reset_mid_frame();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
